// File: rtl/result_event_fifo_if.sv
// Bundle of the result buses feeding the event FIFO and its valid/ready drain side.
// master = the FIFO itself, slave = the upstream stage plus the consumer.
interface result_event_fifo_if #(
  parameter int DATA_W = 4,
  parameter int PTR_W  = 2
);
  logic [DATA_W-1:0] f_in;
  logic [DATA_W-1:0] t_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W:0]   out_data;
  logic [PTR_W:0]    count;
  logic              full;
  logic [7:0]        drop_cnt;

  modport master (
    input  f_in, t_in, out_ready,
    output out_valid, out_data, count, full, drop_cnt
  );

  modport slave (
    output f_in, t_in, out_ready,
    input  out_valid, out_data, count, full, drop_cnt
  );
endinterface

// File: rtl/result_event_fifo.sv
// Logs every change on the f/t result buses as a tagged {src, value} event into a
// small first-word-fall-through FIFO; lost events are counted in a saturating counter.
module result_event_fifo #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  result_event_fifo_if.master  bus
);
  logic [DATA_W-1:0] f_prev_q, f_prev_d;
  logic [DATA_W-1:0] t_prev_q, t_prev_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;
  logic [DATA_W:0]   mem [DEPTH];

  logic            f_ev, t_ev, ev;
  logic            full, empty, pop, push;
  logic [DATA_W:0] ev_data;
  logic [1:0]      drop_inc;
  logic [8:0]      drop_sum;

  assign f_ev    = (bus.f_in != f_prev_q);
  assign t_ev    = (bus.t_in != t_prev_q);
  assign ev      = f_ev | t_ev;
  // f wins when both buses change in the same cycle
  assign ev_data = f_ev ? {1'b0, bus.f_in} : {1'b1, bus.t_in};

  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign pop   = !empty & bus.out_ready;
  assign push  = ev & (!full | pop);

  assign bus.out_valid = !empty;
  assign bus.full      = full;
  assign bus.count     = count_q;
  assign bus.drop_cnt  = drop_cnt_q;
  // Memory is not reset, so mask the head while empty to present 0 after reset
  assign bus.out_data  = empty ? '0 : mem[rd_ptr_q];

  always_comb begin
    f_prev_d   = bus.f_in;
    t_prev_d   = bus.t_in;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    drop_inc   = {1'b0, f_ev & t_ev} + {1'b0, ev & full & !pop};
    drop_sum   = {1'b0, drop_cnt_q} + {7'b0, drop_inc};
    drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];

    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_prev_q   <= '0;
      t_prev_q   <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      f_prev_q   <= f_prev_d;
      t_prev_q   <= t_prev_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr_q] <= ev_data;
  end
endmodule
